// File: rtl/dutsig_pkg.sv
// dutsig_pkg: shared state encodings and defaults for the DUT signal vector sequencer
package dutsig_pkg;
  localparam int PERIOD_W_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, LOADING = 2'd1, ARMED = 2'd2} state_e;
endpackage

// File: rtl/dutsig_vec_seq_if.sv
// dutsig_vec_seq_if: host/downstream bundle of the vector sequencer.
// master = host side (drives RUN, PERIOD, VEC, VEC_VALID, CLR_ERR),
// slave = sequencer (drives VEC_READY, D_OUT, LOAD, TRANSFER, UNDERRUN,
// plus XFER_CNT when DUTSIG_VEC_SEQ_XFER_CNT_EN is defined).
interface dutsig_vec_seq_if import dutsig_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int PERIOD_W = PERIOD_W_DEF
);
  logic RUN;
  logic [PERIOD_W-1:0] PERIOD;
  logic [WIDTH-1:0] VEC;
  logic VEC_VALID;
  logic VEC_READY;
  logic CLR_ERR;
  logic [WIDTH-1:0] D_OUT;
  logic LOAD;
  logic TRANSFER;
  logic UNDERRUN;
`ifdef DUTSIG_VEC_SEQ_XFER_CNT_EN
  logic [15:0] XFER_CNT;
  modport master (output RUN, PERIOD, VEC, VEC_VALID, CLR_ERR,
                  input VEC_READY, D_OUT, LOAD, TRANSFER, UNDERRUN, XFER_CNT);
  modport slave (input RUN, PERIOD, VEC, VEC_VALID, CLR_ERR,
                 output VEC_READY, D_OUT, LOAD, TRANSFER, UNDERRUN, XFER_CNT);
`else
  modport master (output RUN, PERIOD, VEC, VEC_VALID, CLR_ERR,
                  input VEC_READY, D_OUT, LOAD, TRANSFER, UNDERRUN);
  modport slave (input RUN, PERIOD, VEC, VEC_VALID, CLR_ERR,
                 output VEC_READY, D_OUT, LOAD, TRANSFER, UNDERRUN);
`endif
endinterface

// File: rtl/dutsig_period_tick.sv
// dutsig_period_tick: vector period counter.
// Ports: CLK, RST (async, active-high), RUN enables counting, PERIOD sets the
// period (0 behaves as 1), TICK flags the last count of each period.
module dutsig_period_tick import dutsig_pkg::*; #(
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RUN,
  input  logic [PERIOD_W-1:0] PERIOD,
  output logic                TICK
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d, last;
  always_comb begin
    last = (PERIOD == '0) ? '0 : PERIOD - PERIOD_W'(1);
    // >= so that shrinking PERIOD below the running count ticks at once
    TICK = RUN && (cnt_q >= last);
    cnt_d = (!RUN || TICK) ? '0 : cnt_q + PERIOD_W'(1);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dutsig_vec_seq.sv
// dutsig_vec_seq: feeds host vectors into DUT-signal double buffers, one per period.
// Ports: CLK, RST (async, active-high), bus (dutsig_vec_seq_if.slave):
//   RUN/PERIOD drive the period counter, VEC/VEC_VALID/VEC_READY hand over a
//   vector, D_OUT/LOAD fill the buffers, TRANSFER moves them to the DUT,
//   UNDERRUN is sticky until CLR_ERR. Macro DUTSIG_VEC_SEQ_XFER_CNT_EN adds
//   the 16-bit wrapping TRANSFER counter XFER_CNT.
module dutsig_vec_seq import dutsig_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input logic CLK,
  input logic RST,
  dutsig_vec_seq_if.slave bus
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic load_q, load_d, xfer_q, xfer_d, und_q, und_d;
  logic tick, accept, armed_tick;
  dutsig_period_tick #(.PERIOD_W(PERIOD_W)) u_tick (
    .CLK(CLK),
    .RST(RST),
    .RUN(bus.RUN),
    .PERIOD(bus.PERIOD),
    .TICK(tick)
  );
  always_comb begin
    accept = (state_q == IDLE) && bus.VEC_VALID;
    armed_tick = (state_q == ARMED) && tick;
    state_d = accept ? LOADING : (state_q == LOADING) ? ARMED : armed_tick ? IDLE : state_q;
    d_out_d = accept ? bus.VEC : d_out_q;
    load_d = accept;
    xfer_d = armed_tick;
    // a tick with nothing armed wins over a same-cycle clear
    und_d = (tick && state_q != ARMED) || (und_q && !bus.CLR_ERR);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      d_out_q <= '0;
      load_q <= 1'b0;
      xfer_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      state_q <= state_d;
      d_out_q <= d_out_d;
      load_q <= load_d;
      xfer_q <= xfer_d;
      und_q <= und_d;
    end
  assign bus.VEC_READY = state_q == IDLE;
  assign bus.D_OUT = d_out_q;
  assign bus.LOAD = load_q;
  assign bus.TRANSFER = xfer_q;
  assign bus.UNDERRUN = und_q;
`ifdef DUTSIG_VEC_SEQ_XFER_CNT_EN
  logic [15:0] xfer_cnt_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) xfer_cnt_q <= '0;
    else xfer_cnt_q <= xfer_cnt_q + 16'(xfer_d);
  assign bus.XFER_CNT = xfer_cnt_q;
`endif
endmodule
